hilo_mdu_ctrl: RTL and testbench

//  Iterative multiply/accumulate sequencer that owns the HI/LO register pair. The ALU keeps

---
 rtl/hilo_mdu_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: iterative multiply / multiply-accumulate sequencer owning HI/LO.
// A 32-step radix-2 shift-add core computes |A|*|B|. The sign is fixed up and the
// result is committed to {Hi,Lo} in a dedicated WRITE cycle.
// Optional macro MDU_DIV_EN adds a restoring divider (DIV/DIVU) in the same CALC slots.
//
// Handshake: Start is consumed on a rising edge when the sequencer is in IDLE or DONE
// and Abort is low. While Busy, Stall=(ReadHiLo|Start) tells the pipeline to hold the
// MFHI/MFLO read or keep Start asserted. Done pulses for one cycle once Hi/Lo hold the result.
module hilo_mdu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       MduOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Abort,
    input  logic             ReadHiLo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [1:0]       o_dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_mcand;   // multiplicand, or divisor for DIV/DIVU
    logic [2*WIDTH-1:0] r_prod;    // {partial product, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0] r_acc;     // HI/LO snapshot for MADD/MSUB
    logic               r_neg;     // negate product / quotient at WRITE
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
`ifdef MDU_DIV_EN
    logic               r_rneg;    // remainder follows the dividend's sign
    logic               r_dz;      // divide by zero
    logic [WIDTH-1:0]   r_a_raw;   // original dividend, returned in Hi on divide by zero
`endif

    logic               w_signed;
    logic               w_multi;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod_s;

    assign w_signed = (MduOp == OP_MULT) || (MduOp == OP_MADD) ||
                      (MduOp == OP_MSUB) || (MduOp == OP_DIV);
`ifdef MDU_DIV_EN
    assign w_multi  = (MduOp != OP_MTHI) && (MduOp != OP_MTLO);
`else
    assign w_multi  = (MduOp[2] == 1'b0);
`endif
    assign w_accept = Start && !Abort && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Magnitudes: negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign w_a_mag  = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_b_mag  = (w_signed && B[WIDTH-1]) ? -B : B;
    assign w_prod_s = r_neg ? -r_prod : r_prod;

    assign Busy        = (r_state != S_IDLE);
    assign Done        = (r_state == S_DONE);
    assign Stall       = (ReadHiLo || Start) && Busy;
    assign Hi          = r_hi;
    assign Lo          = r_lo;
    assign o_dbg_state = r_state;

`ifdef MDU_DIV_EN
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;
    assign w_rem_sh = r_prod[2*WIDTH-1:WIDTH-1];
    assign w_trial  = w_rem_sh - {1'b0, r_mcand};
`endif

    // One iteration of the shift-add multiplier (or restoring divider for DIV/DIVU).
    always_comb begin
        w_add  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_step = {w_add, r_prod[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (r_op[2]) begin
            if (!w_trial[WIDTH])
                w_step = {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
            else
                w_step = {w_rem_sh[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
        end
`endif
    end

    // Sequencer FSM, operand latching, iteration and HI/LO commit.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
`ifdef MDU_DIV_EN
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_a_raw <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        if (w_multi) begin
                            r_state <= S_CALC;
                            r_cnt   <= '0;
                            r_op    <= MduOp;
                            r_acc   <= {r_hi, r_lo};
                            r_mcand <= w_a_mag;
                            r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                            r_neg   <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MDU_DIV_EN
                            r_rneg  <= w_signed && A[WIDTH-1];
                            r_dz    <= (B == '0);
                            r_a_raw <= A;
                            if (MduOp[2]) begin
                                r_mcand <= w_b_mag;
                                r_prod  <= {{WIDTH{1'b0}}, w_a_mag};
                            end
`endif
                        end else if (MduOp == OP_MTHI) begin
                            r_hi <= A;
                        end else if (MduOp == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                S_CALC: begin
                    if (Abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_prod <= w_step;
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= S_WRITE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_state <= Abort ? S_IDLE : S_DONE;
                    if (!Abort) begin
                        case (r_op)
                            OP_MADD:  {r_hi, r_lo} <= r_acc + w_prod_s;
                            OP_MSUB:  {r_hi, r_lo} <= r_acc - w_prod_s;
                            OP_MULTU: {r_hi, r_lo} <= r_prod;
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                if (r_dz) begin
                                    r_lo <= '1;
                                    r_hi <= r_a_raw;
                                end else begin
                                    r_lo <= r_neg  ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
                                    r_hi <= r_rneg ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
                                end
                            end
`endif
                            default:  {r_hi, r_lo} <= w_prod_s;
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: reset, signed/unsigned multiply, MADD/MSUB,
// MTHI/MTLO, interlocks, abort, mid-op reset, back-to-back issue, illegal/DIV ops.
module tb_hilo_mdu_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [2:0]  MduOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Abort;
    logic        ReadHiLo;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [1:0]  o_dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    hilo_mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .MduOp(MduOp), .A(A), .B(B),
        .Abort(Abort), .ReadHiLo(ReadHiLo), .Busy(Busy), .Stall(Stall), .Done(Done),
        .Hi(Hi), .Lo(Lo), .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive one Start pulse; returns just after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1; MduOp = op; A = a; B = b;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    // wait (bounded) for Done, check latency in edges and the committed {Hi,Lo}
    task automatic wait_done(input string tag, input int start_edges);
        int edges;
        logic [63:0] exp;
        edges = start_edges;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) break;
            @(posedge Clk);
            edges++;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check({tag, "_done"}, 64'(Done), 64'd1);
        check({tag, "_lat"}, 64'(edges), 64'd34);
        check({tag, "_hilo"}, {Hi, Lo}, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        exp_q.push_back(exp);
        issue(op, a, b);
        wait_done(tag, 1);
    endtask

    // MTHI/MTLO: single edge, no Busy, no Done
    task automatic move_to(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [63:0] exp);
        issue(op, a, 32'h0);
        @(negedge Clk);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_done"}, 64'(Done), 64'd0);
        check({tag, "_hilo"}, {Hi, Lo}, exp);
    endtask

    initial begin
        logic saw_done;
        Rst = 1'b1; Start = 1'b0; MduOp = 3'b000; A = '0; B = '0;
        Abort = 1'b0; ReadHiLo = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_hilo", {Hi, Lo}, 64'h0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        ReadHiLo = 1'b1;
        #1 check("idle_read_stall", 64'(Stall), 64'd0);
        ReadHiLo = 1'b0;

        // multiplies
        run_op("mult_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge Clk);
        check("done_pulse_len", 64'(Done), 64'd0);
        check("idle_after_done", 64'(Busy), 64'd0);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_min_sq", 3'b000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("mult_min_x1", 3'b000, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);

        // moves and accumulate
        move_to("mthi0", 3'b110, 32'h0, 64'h0000_0000_8000_0000);
        move_to("mtlo_a", 3'b111, 32'h0000_000A, 64'h0000_0000_0000_000A);
        run_op("madd_2x3", 3'b010, 32'd2, 32'd3, 64'h0000_0000_0000_0010);
        move_to("mtlo0", 3'b111, 32'h0, 64'h0);
        run_op("msub_4x4", 3'b011, 32'd4, 32'd4, 64'hFFFF_FFFF_FFFF_FFF0);
        run_op("madd_m1x1", 3'b010, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFEF);

        // Start pulse at counter=5 (after E5) is ignored while Busy
        exp_q.push_back(64'h0000_0000_0000_0031);
        issue(3'b000, 32'd7, 32'd7);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Start = 1'b1; MduOp = 3'b111; A = 32'd123;
        #1 check("busy_start_stall", 64'(Stall), 64'd1);
        @(posedge Clk);
        #1 Start = 1'b0;
        wait_done("mult_7x7_ign", 7);

        // ReadHiLo while busy, then Abort at counter=20
        move_to("mtlo_55", 3'b111, 32'h55, 64'h0000_0000_0000_0055);
        issue(3'b000, 32'd7, 32'd7);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("calc_state", 64'(o_dbg_state), 64'd1);
        ReadHiLo = 1'b1;
        #1 check("busy_read_stall", 64'(Stall), 64'd1);
        ReadHiLo = 1'b0;
        repeat (17) @(posedge Clk);
        @(negedge Clk);
        Abort = 1'b1;
        @(posedge Clk);
        #1 Abort = 1'b0;
        @(negedge Clk);
        check("abort_busy", 64'(Busy), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            saw_done = saw_done | Done;
            @(negedge Clk);
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_hilo", {Hi, Lo}, 64'h0000_0000_0000_0055);

        // Abort together with Start in IDLE: Start ignored
        @(negedge Clk);
        Start = 1'b1; Abort = 1'b1; MduOp = 3'b000; A = 32'd3; B = 32'd3;
        @(posedge Clk);
        #1 Start = 1'b0; Abort = 1'b0;
        @(negedge Clk);
        check("abort_start_busy", 64'(Busy), 64'd0);

`ifdef MDU_DIV_EN
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_9_0", 3'b101, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
        move_to("mtlo_55b", 3'b111, 32'h55, 64'h0000_0000_0000_0055);
`else
        issue(3'b100, 32'd9, 32'd3);
        @(negedge Clk);
        check("illegal_busy", 64'(Busy), 64'd0);
        check("illegal_hilo", {Hi, Lo}, 64'h0000_0000_0000_0055);
`endif

        // back-to-back: Start held through DONE is accepted at the DONE->IDLE edge
        exp_q.push_back(64'h0000_0000_0000_000C);
        exp_q.push_back(64'h0000_0000_0000_001E);
        @(negedge Clk);
        Start = 1'b1; MduOp = 3'b001; A = 32'd3; B = 32'd4;
        @(posedge Clk);
        wait_done("b2b_first", 1);
        check("done_stall", 64'(Stall), 64'd1);
        A = 32'd5; B = 32'd6;
        @(posedge Clk);
        #1 Start = 1'b0;
        wait_done("b2b_second", 1);

        // synchronous reset at counter=10 discards the op and clears HI/LO
        issue(3'b001, 32'd11, 32'd13);
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_state", 64'(o_dbg_state), 64'd0);
        check("midrst_hilo", {Hi, Lo}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
